// File: rtl/generation_tick_generator.sv
// generation_tick_generator: single-clock generation-rate timer with pause, single-step and counters
module generation_tick_generator #(
  parameter int BASE_CYCLES = 6_250_000,
  parameter int RATE_COUNT = 4,
  parameter int RATE_WIDTH = 2,
  parameter int GEN_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [RATE_WIDTH-1:0] rate_select,
  input  logic                  pause,
  input  logic                  step,
  output logic                  tick,
  output logic [GEN_WIDTH-1:0]  generation,
  output logic [7:0]            heartbeat
);
  localparam int PW = $clog2(BASE_CYCLES);
  typedef enum logic {RUN, PAUSED} mode_t;
  mode_t                 mode;
  logic [PW-1:0]         pre_q;
  logic [RATE_COUNT-1:0] oct_q, mask;
  logic [GEN_WIDTH-1:0]  gen_q;
  logic [7:0]            hb_q;
  logic                  step_q, tick_q, tick_d, base_strobe, run_hit, step_edge;
  int                    eff_rate;
  // rate decode, strobes and next tick; the mode follows pause directly so pausing suppresses a same-cycle hit
  always_comb begin
    mode = pause ? PAUSED : RUN;
    base_strobe = pre_q == PW'(BASE_CYCLES - 1);
    eff_rate = int'(rate_select) > RATE_COUNT - 1 ? RATE_COUNT - 1 : int'(rate_select);
    mask = RATE_COUNT'((32'd1 << eff_rate) - 32'd1);
    run_hit = base_strobe & ((oct_q & mask) == mask);
    step_edge = step & ~step_q;
    tick_d = mode == PAUSED ? step_edge : run_hit;
  end
  // prescaler, octave and heartbeat counters, step history, registered tick and generation count
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
      oct_q <= '0;
      hb_q <= '0;
      step_q <= 1'b1;
      tick_q <= 1'b0;
      gen_q <= '0;
    end else begin
      pre_q <= base_strobe ? '0 : pre_q + PW'(1);
      oct_q <= oct_q + RATE_COUNT'(base_strobe);
      hb_q <= hb_q + 8'(base_strobe);
      step_q <= step;
      tick_q <= tick_d;
      gen_q <= gen_q + GEN_WIDTH'(tick_q);
    end
  end
  assign tick = tick_q;
  assign generation = gen_q;
  assign heartbeat = hb_q;
endmodule

// File: tb/tb_generation_tick_generator.sv
// tb_generation_tick_generator: scoreboard bench, expected ticks queued by stimulus and checked by a monitor
module tb_generation_tick_generator;
  typedef struct {int cyc; int gen;} exp_t;
  logic       clock = 1'b0, reset = 1'b1, pause = 1'b0, step = 1'b0, tick;
  logic [2:0] rate_select = 3'd0;
  logic [3:0] generation;
  logic [7:0] heartbeat;
  int         cyc = 0, checks = 0, failures = 0;
  exp_t       q[$];
  exp_t       e;

  generation_tick_generator #(.BASE_CYCLES(4), .RATE_COUNT(4), .RATE_WIDTH(3), .GEN_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .rate_select(rate_select), .pause(pause), .step(step),
    .tick(tick), .generation(generation), .heartbeat(heartbeat));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int g);
    q.push_back('{c, g});
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && tick === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: tick high at cycle %0d with none expected", cyc);
      end else begin
        e = q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_gen", int'(generation), e.gen);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_tick", int'(tick), 0);
    chk("reset_gen", int'(generation), 0);
    chk("reset_hb", int'(heartbeat), 0);
    // rate 0
    for (int k = 1; k <= 4; k++) push(4 * k, k - 1);
    goto(18);
    chk("r0_gen", int'(generation), 4);
    chk("r0_hb", int'(heartbeat), 4);
    chk("r0_drained", q.size(), 0);
    // rate 2
    rate_select = 3'd2;
    do_reset();
    push(16, 0);
    push(32, 1);
    goto(41);
    chk("r2_gen", int'(generation), 2);
    chk("r2_hb", int'(heartbeat), 10);
    chk("r2_drained", q.size(), 0);
    // clamp 7 -> 3
    rate_select = 3'd7;
    do_reset();
    push(32, 0);
    push(64, 1);
    goto(70);
    chk("clamp_gen", int'(generation), 2);
    chk("clamp_drained", q.size(), 0);
    // pause and step
    rate_select = 3'd0;
    pause = 1'b1;
    do_reset();
    goto(10);
    push(11, 0);
    step = 1'b1;
    goto(20);
    step = 1'b0;
    goto(25);
    chk("step_gen", int'(generation), 1);
    goto(30);
    push(31, 1);
    step = 1'b1;
    goto(31);
    step = 1'b0;
    goto(33);
    chk("step2_gen", int'(generation), 2);
    chk("paused_hb", int'(heartbeat), 8);
    pause = 1'b0;
    push(36, 2);
    push(40, 3);
    push(44, 4);
    goto(37);
    step = 1'b1;
    goto(38);
    step = 1'b0;
    goto(39);
    step = 1'b1;
    goto(41);
    step = 1'b0;
    goto(46);
    chk("run_step_gen", int'(generation), 5);
    chk("run_step_drained", q.size(), 0);
    // wrap and reset mid-run
    do_reset();
    for (int k = 1; k <= 17; k++) push(4 * k, (k - 1) % 16);
    goto(66);
    chk("wrap_gen", int'(generation), 0);
    goto(69);
    step = 1'b1;
    goto(70);
    chk("wrap_drained", q.size(), 0);
    do_reset();
    chk("mid_reset_tick", int'(tick), 0);
    chk("mid_reset_gen", int'(generation), 0);
    chk("mid_reset_hb", int'(heartbeat), 0);
    push(4, 0);
    goto(6);
    chk("post_reset_gen", int'(generation), 1);
    chk("post_reset_drained", q.size(), 0);
    // step held high through reset while paused gives no edge
    pause = 1'b1;
    do_reset();
    goto(10);
    chk("held_step_gen", int'(generation), 0);
    chk("held_step_drained", q.size(), 0);
    step = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
